// File: rtl/traffic_light_pkg.sv
// Shared traffic-light definitions: phase and fault encodings, lamp bit positions,
// default phase durations, and the phase decode / sequence legality helpers.
package traffic_light_pkg;

    localparam int CNT_W = 36;

    localparam logic [CNT_W-1:0] TL_RED_CYC = 36'd60000000000;
    localparam logic [CNT_W-1:0] TL_YEL_CYC = 36'd3000000000;
    localparam logic [CNT_W-1:0] TL_GRN_CYC = 36'd30000000000;
    localparam logic [CNT_W-1:0] TL_TOL_CYC = 36'd16;

    localparam int LAMP_R = 2;
    localparam int LAMP_Y = 1;
    localparam int LAMP_G = 0;

    typedef enum logic [2:0] {
        PH_DARK            = 3'd0,
        PH_RED             = 3'd1,
        PH_YEL_AFTER_RED   = 3'd2,
        PH_GREEN           = 3'd3,
        PH_YEL_AFTER_GREEN = 3'd4,
        PH_YEL_FLASH       = 3'd5
    } phase_e;

    typedef enum logic [2:0] {
        FLT_NONE  = 3'd0,
        FLT_COMBO = 3'd1,
        FLT_SEQ   = 3'd2,
        FLT_SHORT = 3'd3,
        FLT_LONG  = 3'd4
    } fault_e;

    function automatic logic is_lit(phase_e ph);
        return ph != PH_DARK;
    endfunction

    // Yellow is ambiguous on its own; the phase it follows decides which yellow it is.
    // Multi-lamp codes resolve by red > yellow > green.
    function automatic phase_e decode_phase(logic [2:0] lamp, phase_e prev);
        phase_e ph;
        ph = prev;
        if (lamp == 3'b000) begin
            ph = PH_DARK;
        end else if (lamp[LAMP_R]) begin
            ph = PH_RED;
        end else if (lamp[LAMP_Y]) begin
            case (prev)
                PH_RED:   ph = PH_YEL_AFTER_RED;
                PH_GREEN: ph = PH_YEL_AFTER_GREEN;
                PH_DARK:  ph = PH_YEL_FLASH;
                default:  ph = prev;
            endcase
        end else begin
            ph = PH_GREEN;
        end
        return ph;
    endfunction

    function automatic logic legal_step(phase_e from, phase_e to);
        logic ok;
        ok = 1'b0;
        case (from)
            PH_DARK:            ok = (to == PH_RED) || (to == PH_YEL_FLASH);
            PH_YEL_FLASH:       ok = (to == PH_DARK);
            PH_RED:             ok = (to == PH_YEL_AFTER_RED);
            PH_YEL_AFTER_RED:   ok = (to == PH_GREEN);
            PH_GREEN:           ok = (to == PH_YEL_AFTER_GREEN);
            PH_YEL_AFTER_GREEN: ok = (to == PH_RED);
            default:            ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/traffic_light_monitor_if.sv
// Lamp inputs, fault clear and monitor status outputs of the traffic light monitor.
// DUR_O is meaningful only in the cycle DUR_VLD_O is high; there is no ready, the monitor never stalls.
interface traffic_light_monitor_if;
    import traffic_light_pkg::*;

    logic             RED_I;
    logic             YELLOW_I;
    logic             GREEN_I;
    logic             FAULT_CLR_I;
    logic [2:0]       PHASE_O;
    logic [CNT_W-1:0] DUR_O;
    logic             DUR_VLD_O;
    logic             FAULT_O;
    logic [2:0]       FAULT_CODE_O;

    modport master (
        output RED_I, YELLOW_I, GREEN_I, FAULT_CLR_I,
        input  PHASE_O, DUR_O, DUR_VLD_O, FAULT_O, FAULT_CODE_O
    );

    modport slave (
        input  RED_I, YELLOW_I, GREEN_I, FAULT_CLR_I,
        output PHASE_O, DUR_O, DUR_VLD_O, FAULT_O, FAULT_CODE_O
    );

endinterface

// File: rtl/tlm_phase_timer.sv
// Lamp sampling, change detection, saturating phase-length counter and the
// short/long comparisons against the nominal length of the phase being timed.
module tlm_phase_timer
    import traffic_light_pkg::*;
#(
    parameter logic [CNT_W-1:0] RED_CYC_P = TL_RED_CYC,
    parameter logic [CNT_W-1:0] YEL_CYC_P = TL_YEL_CYC,
    parameter logic [CNT_W-1:0] GRN_CYC_P = TL_GRN_CYC,
    parameter logic [CNT_W-1:0] TOL_CYC_P = TL_TOL_CYC
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [2:0]       i_lamp,
    input  phase_e           i_phase,
    output logic [2:0]       o_lamp_s,
    output logic             o_change,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_short,
    output logic             o_long
);

    localparam int CW = CNT_W + 2;

    logic [2:0]       r_s;
    logic [2:0]       r_p;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_nom;
    logic             w_change;

    assign w_change = (r_s != r_p);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s   <= '0;
            r_p   <= '0;
            r_cnt <= '0;
        end else begin
            r_s <= i_lamp;
            r_p <= r_s;
            if (w_change) begin
                r_cnt <= CNT_W'(1);
            end else if (!(&r_cnt)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // i_phase is the phase of r_p, i.e. the phase r_cnt is currently timing.
    always_comb begin
        w_nom = '0;
        case (i_phase)
            PH_RED:                                             w_nom = RED_CYC_P;
            PH_YEL_AFTER_RED, PH_YEL_AFTER_GREEN, PH_YEL_FLASH: w_nom = YEL_CYC_P;
            PH_GREEN:                                           w_nom = GRN_CYC_P;
            default:                                            w_nom = '0;
        endcase
    end

    // Widened so that N+1-TOL below zero and N+2+TOL above all-ones compare correctly.
    assign o_short  = ({2'b00, r_cnt} + {2'b00, TOL_CYC_P}) < ({2'b00, w_nom} + CW'(1));
    assign o_long   = {2'b00, r_cnt} >= ({2'b00, w_nom} + {2'b00, TOL_CYC_P} + CW'(2));
    assign o_lamp_s = r_s;
    assign o_change = w_change;
    assign o_cnt    = r_cnt;

endmodule

// File: rtl/traffic_light_monitor.sv
// Traffic light monitor top: phase decode FSM, fault detection/capture, duration report.
// Define TLM_INPUT_SYNC_EN to put a two-flop synchroniser on each lamp line.
module traffic_light_monitor
    import traffic_light_pkg::*;
#(
    parameter logic [CNT_W-1:0] RED_CYC_P = TL_RED_CYC,
    parameter logic [CNT_W-1:0] YEL_CYC_P = TL_YEL_CYC,
    parameter logic [CNT_W-1:0] GRN_CYC_P = TL_GRN_CYC,
    parameter logic [CNT_W-1:0] TOL_CYC_P = TL_TOL_CYC
) (
    input  logic                   CLK_I,
    input  logic                   RST_N_I,
    traffic_light_monitor_if.slave bus
);

    logic [2:0]       w_lamp_pin;
    logic [2:0]       w_lamp_in;
    logic [2:0]       w_lamp_s;
    logic             w_change;
    logic [CNT_W-1:0] w_cnt;
    logic             w_short_raw;
    logic             w_long_raw;

    phase_e           r_phase;
    phase_e           w_phase_nxt;
    logic             r_unchecked;
    logic             r_fault;
    fault_e           r_fault_code;
    fault_e           w_fault_code;
    logic [CNT_W-1:0] r_dur;
    logic             r_dur_vld;

    logic             w_lit;
    logic             w_checked;
    logic             w_combo;
    logic             w_seq;
    logic             w_short;
    logic             w_long;

    assign w_lamp_pin = {bus.RED_I, bus.YELLOW_I, bus.GREEN_I};

`ifdef TLM_INPUT_SYNC_EN
    logic [2:0] r_sync_1;
    logic [2:0] r_sync_2;

    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            r_sync_1 <= '0;
            r_sync_2 <= '0;
        end else begin
            r_sync_1 <= w_lamp_pin;
            r_sync_2 <= r_sync_1;
        end
    end

    assign w_lamp_in = r_sync_2;
`else
    assign w_lamp_in = w_lamp_pin;
`endif

    tlm_phase_timer #(
        .RED_CYC_P (RED_CYC_P),
        .YEL_CYC_P (YEL_CYC_P),
        .GRN_CYC_P (GRN_CYC_P),
        .TOL_CYC_P (TOL_CYC_P)
    ) u_timer (
        .i_clk    (CLK_I),
        .i_rst_n  (RST_N_I),
        .i_lamp   (w_lamp_in),
        .i_phase  (r_phase),
        .o_lamp_s (w_lamp_s),
        .o_change (w_change),
        .o_cnt    (w_cnt),
        .o_short  (w_short_raw),
        .o_long   (w_long_raw)
    );

    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            r_phase <= PH_DARK;
        end else begin
            r_phase <= w_phase_nxt;
        end
    end

    always_comb begin
        w_phase_nxt = r_phase;
        if (w_change) begin
            w_phase_nxt = decode_phase(w_lamp_s, r_phase);
        end
    end

    // r_phase is still the phase that is ending while w_change is high.
    assign w_lit     = is_lit(r_phase);
    assign w_checked = w_change && !r_unchecked;
    assign w_combo   = (w_lamp_s[LAMP_R] & w_lamp_s[LAMP_Y]) |
                       (w_lamp_s[LAMP_R] & w_lamp_s[LAMP_G]) |
                       (w_lamp_s[LAMP_Y] & w_lamp_s[LAMP_G]);
    assign w_seq     = w_checked && !legal_step(r_phase, w_phase_nxt);
    assign w_short   = w_checked && w_lit && w_short_raw;
    assign w_long    = w_lit && w_long_raw;

    always_comb begin
        w_fault_code = FLT_NONE;
        if (w_combo) begin
            w_fault_code = FLT_COMBO;
        end else if (w_seq) begin
            w_fault_code = FLT_SEQ;
        end else if (w_short) begin
            w_fault_code = FLT_SHORT;
        end else if (w_long) begin
            w_fault_code = FLT_LONG;
        end
    end

    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            r_fault      <= 1'b0;
            r_fault_code <= FLT_NONE;
            r_unchecked  <= 1'b1;
            r_dur        <= '0;
            r_dur_vld    <= 1'b0;
        end else begin
            // A fault seen in the clear cycle is captured instead of being cleared.
            if ((w_fault_code != FLT_NONE) && (!r_fault || bus.FAULT_CLR_I)) begin
                r_fault      <= 1'b1;
                r_fault_code <= w_fault_code;
            end else if (bus.FAULT_CLR_I) begin
                r_fault      <= 1'b0;
                r_fault_code <= FLT_NONE;
            end

            if (bus.FAULT_CLR_I) begin
                r_unchecked <= 1'b1;
            end else if (w_change) begin
                r_unchecked <= 1'b0;
            end

            r_dur_vld <= w_change && w_lit;
            if (w_change && w_lit) begin
                r_dur <= w_cnt;
            end
        end
    end

    assign bus.PHASE_O      = r_phase;
    assign bus.DUR_O        = r_dur;
    assign bus.DUR_VLD_O    = r_dur_vld;
    assign bus.FAULT_O      = r_fault;
    assign bus.FAULT_CODE_O = r_fault_code;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor with short durations (R=20, Y=3, G=10, TOL=1).
module tb_traffic_light_monitor;

    localparam logic [2:0] L_OFF = 3'b000;
    localparam logic [2:0] L_R   = 3'b100;
    localparam logic [2:0] L_Y   = 3'b010;
    localparam logic [2:0] L_G   = 3'b001;
    localparam logic [2:0] L_RY  = 3'b110;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    logic [38:0] exp_q[$];
    logic [2:0]  exp_ph_q[$];
    logic [2:0]  prev_phase;

    traffic_light_monitor_if bus ();

    traffic_light_monitor #(
        .RED_CYC_P (36'd20),
        .YEL_CYC_P (36'd3),
        .GRN_CYC_P (36'd10),
        .TOL_CYC_P (36'd1)
    ) dut (
        .CLK_I   (clk),
        .RST_N_I (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required normal completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic hold(input logic [2:0] lamp, input int n);
        @(negedge clk);
        bus.RED_I    = lamp[2];
        bus.YELLOW_I = lamp[1];
        bus.GREEN_I  = lamp[0];
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic push_ph(input logic [2:0] ph);
        exp_ph_q.push_back(ph);
    endtask

    task automatic push_dur(input logic [2:0] ph, input logic [35:0] dur);
        exp_q.push_back({ph, dur});
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_phase"}, 64'(bus.PHASE_O), 64'd0);
        check({tag, "_dur"}, 64'(bus.DUR_O), 64'd0);
        check({tag, "_dur_vld"}, 64'(bus.DUR_VLD_O), 64'd0);
        check({tag, "_fault"}, 64'(bus.FAULT_O), 64'd0);
        check({tag, "_code"}, 64'(bus.FAULT_CODE_O), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.RED_I       = 1'b0;
        bus.YELLOW_I    = 1'b0;
        bus.GREEN_I     = 1'b0;
        bus.FAULT_CLR_I = 1'b0;
        rst_n           = 1'b0;
        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
    endtask

    task automatic check_fault(input string name, input logic flag, input logic [2:0] code);
        check({name, "_fault"}, 64'(bus.FAULT_O), 64'(flag));
        check({name, "_code"}, 64'(bus.FAULT_CODE_O), 64'(code));
    endtask

    // Monitor: phase changes and duration reports are matched against the expected queues.
    always @(negedge clk) begin
        logic [38:0] e;
        if (!rst_n) begin
            prev_phase = 3'd0;
        end else begin
            if (bus.PHASE_O != prev_phase) begin
                if (exp_ph_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL phase_unexpected: got %0d, required no change", bus.PHASE_O);
                end else begin
                    check("phase", 64'(bus.PHASE_O), 64'(exp_ph_q.pop_front()));
                end
                prev_phase = bus.PHASE_O;
            end
            if (bus.DUR_VLD_O) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL dur_unexpected: got %0d, required no report", bus.DUR_O);
                end else begin
                    e = exp_q.pop_front();
                    check("dur_len", 64'(bus.DUR_O), 64'(e[35:0]));
                    check("dur_phase", 64'(bus.PHASE_O), 64'(e[38:36]));
                end
            end
        end
    end

    initial begin
        n_cmp           = 0;
        n_err           = 0;
        prev_phase      = 3'd0;
        rst_n           = 1'b0;
        bus.RED_I       = 1'b0;
        bus.YELLOW_I    = 1'b0;
        bus.GREEN_I     = 1'b0;
        bus.FAULT_CLR_I = 1'b0;

        // Legal full cycle
        do_reset();
        hold(L_OFF, 5);
        push_ph(3'd1);                     hold(L_R, 21);
        push_ph(3'd2); push_dur(3'd2, 21); hold(L_Y, 4);
        push_ph(3'd3); push_dur(3'd3, 4);  hold(L_G, 11);
        push_ph(3'd4); push_dur(3'd4, 11); hold(L_Y, 4);
        push_ph(3'd1); push_dur(3'd1, 4);  hold(L_R, 21);
        check_fault("cycle", 1'b0, 3'd0);

        // Idle yellow flash
        do_reset();
        hold(L_OFF, 3);
        for (int i = 0; i < 3; i++) begin
            push_ph(3'd5);                    hold(L_Y, 4);
            push_ph(3'd0); push_dur(3'd0, 4); hold(L_OFF, 4);
        end
        check_fault("flash", 1'b0, 3'd0);

        // Short green
        do_reset();
        hold(L_OFF, 2);
        push_ph(3'd1);                     hold(L_R, 21);
        push_ph(3'd2); push_dur(3'd2, 21); hold(L_Y, 4);
        push_ph(3'd3); push_dur(3'd3, 4);  hold(L_G, 8);
        push_ph(3'd4); push_dur(3'd4, 8);  hold(L_Y, 1);
        check_fault("short_t0", 1'b0, 3'd0);
        @(negedge clk);
        check_fault("short_t1", 1'b0, 3'd0);
        @(negedge clk);
        check_fault("short_t2", 1'b1, 3'd3);

        // Stuck red
        do_reset();
        hold(L_OFF, 2);
        push_ph(3'd1); hold(L_R, 1);
        repeat (24) @(negedge clk);
        check_fault("long_pre", 1'b0, 3'd0);
        @(negedge clk);
        check_fault("long", 1'b1, 3'd4);

        // Lamp combination, first fault kept, clear, unchecked phase
        do_reset();
        hold(L_OFF, 2);
        push_ph(3'd1);                     hold(L_R, 21);
        push_dur(3'd1, 21);                hold(L_RY, 1);
        push_ph(3'd3); push_dur(3'd3, 1);  hold(L_G, 1);
        @(negedge clk);
        check_fault("combo", 1'b1, 3'd1);
        repeat (3) @(negedge clk);
        push_ph(3'd4); push_dur(3'd4, 5);  hold(L_Y, 1);
        repeat (2) @(negedge clk);
        check_fault("combo_keep", 1'b1, 3'd1);
        bus.FAULT_CLR_I = 1'b1;
        @(negedge clk);
        bus.FAULT_CLR_I = 1'b0;
        check_fault("clear", 1'b0, 3'd0);
        push_ph(3'd3); push_dur(3'd3, 4);  hold(L_G, 11);
        push_ph(3'd4); push_dur(3'd4, 11); hold(L_Y, 1);
        repeat (2) @(negedge clk);
        check_fault("unchecked", 1'b0, 3'd0);

        // Skipped yellow, then reset mid-green
        do_reset();
        hold(L_OFF, 2);
        push_ph(3'd1);                     hold(L_R, 21);
        push_ph(3'd3); push_dur(3'd3, 21); hold(L_G, 1);
        repeat (2) @(negedge clk);
        check_fault("seq", 1'b1, 3'd2);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("async_rst");
        do_reset();
        repeat (3) @(negedge clk);

        check("exp_q_left", 64'(exp_q.size()), 64'd0);
        check("exp_ph_q_left", 64'(exp_ph_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/traffic_light_monitor.md
# traffic_light_monitor

Receiving-end checker for the three-lamp traffic light controller. Samples the RED/YELLOW/GREEN lamp drive lines, decodes the current phase, measures each lamp-on duration, and flags illegal lamp combinations, out-of-order phase sequences, and out-of-tolerance phase lengths. Sits beside the controller on the same clock, feeding a status/fault register or a safety cut-off.

## Interface
- RED_CYC_P, 36'd60000000000: nominal red duration N_R; lamp is expected on for N_R+1 cycles.
- YEL_CYC_P, 36'd3000000000: nominal yellow duration N_Y; expected on for N_Y+1 cycles.
- GRN_CYC_P, 36'd30000000000: nominal green duration N_G; expected on for N_G+1 cycles.
- TOL_CYC_P, 36'd16: allowed ± deviation in cycles.
- CLK_I  in  1  single clock, rising edge.
- RST_N_I  in  1  reset, asynchronous, active-low.
- RED_I / YELLOW_I / GREEN_I  in  1 each  lamp drive lines from the controller.
- FAULT_CLR_I  in  1  one-cycle pulse; clears the sticky fault.
- PHASE_O  out  3  decoded phase: 0 DARK, 1 RED, 2 YEL_AFTER_RED, 3 GREEN, 4 YEL_AFTER_GREEN, 5 YEL_FLASH.
- DUR_O  out  36  length in cycles of the phase that just ended.
- DUR_VLD_O  out  1  one-cycle pulse when DUR_O updates.
- FAULT_O  out  1  sticky fault flag.
- FAULT_CODE_O  out  3  first fault captured: 0 none, 1 COMBO, 2 SEQ, 3 SHORT, 4 LONG.

## Operation
- Lamp code sampled into reg s every cycle; prev reg p = s delayed by one cycle. Change event when s != p.
- Stability counter cnt (36 bit, saturating at all-ones) is set to 1 on a change, otherwise increments.
- Any cycle with more than one lamp in s: COMBO fault.
- Legal transitions on change: DARK→RED, DARK→YEL_FLASH, YEL_FLASH→DARK, RED→YEL_AFTER_RED, YEL_AFTER_RED→GREEN, GREEN→YEL_AFTER_GREEN, YEL_AFTER_GREEN→RED. Any other transition (including lit→DARK outside YEL_FLASH): SEQ fault; PHASE_O still follows the lamps.
- On leaving a lit phase, ended length L=cnt checked against [N+1−TOL, N+1+TOL]; L below: SHORT fault. DARK length never checked.
- While lit, cnt reaching N+2+TOL: LONG fault immediately (stuck-lamp detection), no waiting for change.
- Same-cycle fault priority: COMBO > SEQ > SHORT > LONG. Only the first fault is captured; later faults do not overwrite FAULT_CODE_O.
- FAULT_CLR_I clears FAULT_O/FAULT_CODE_O next cycle; a fault detected in the clear cycle wins and is captured.
- Unchecked flag: set by reset and by FAULT_CLR_I; the first phase ending afterwards gets no SHORT check and its sequence transition is accepted; flag clears on that change.

## Timing
- Reset values: PHASE_O=0, DUR_O=0, DUR_VLD_O=0, FAULT_O=0, FAULT_CODE_O=0, cnt=0, unchecked=1.
- Lamp pin change → PHASE_O, DUR_O, DUR_VLD_O, SHORT/SEQ fault: 2 cycles. COMBO: 2 cycles after pin.
- All outputs registered; reset assertion mid-phase clears everything asynchronously; monitor resumes unchecked.

## Configuration
- TLM_INPUT_SYNC_EN defined: two-flop synchroniser per lamp line ahead of s; all pin-to-output latencies +2 cycles. Undefined: lines sampled directly into s (same-clock source only).

## Structure
- Shared package traffic_light_pkg: phase encodings, fault codes, default duration constants (shared with the controller).
- One sub-module: tlm_phase_timer (saturating cnt, change detect, range compare against selected N and TOL).

## Test plan
Use RED_CYC_P=20, YEL_CYC_P=3, GRN_CYC_P=10, TOL_CYC_P=1.
- Reset, DARK 5, RED 21, YEL 4, GREEN 11, YEL 4, RED 21 → PHASE_O 1,2,3,4,1; DUR_VLD_O pulses with DUR_O 21,4,11,4; FAULT_O=0.
- Idle flash: YEL 4 / DARK 4 repeated ×3 → PHASE_O alternates 5/0; no fault.
- After legal RED, GREEN on for 8 → FAULT_CODE_O=3, FAULT_O high 2 cycles after green drops.
- RED held on 30 cycles → FAULT_CODE_O=4 at cnt=23, before red drops.
- RED and YELLOW both high one cycle, then GREEN short → FAULT_CODE_O=1 stays (first wins); FAULT_CLR_I pulse → cleared next cycle, next phase unchecked.
- RED 21 then direct GREEN → FAULT_CODE_O=2; RST_N_I low mid-GREEN → all outputs 0 immediately.
